// File: rtl/polybius_code_serializer_if.sv
// polybius_code_serializer_if
//   Handshake bundle between the Polybius encryptor control, the code
//   serializer and the character sink.
//   code_in/code_valid/code_ready : cipher code channel (upstream -> block)
//   char_out/char_valid/char_ready: ASCII character channel (block -> sink)
//   err_count                     : saturating count of unencodable codes
//   modport slave  : the serializer side
//   modport master : the environment (upstream producer + character sink)
interface polybius_code_serializer_if;
  logic [7:0]  code_in;
  logic        code_valid;
  logic        code_ready;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready;
  logic [15:0] err_count;

  modport slave (
    input  code_in,
    input  code_valid,
    input  char_ready,
    output code_ready,
    output char_out,
    output char_valid,
    output err_count
  );

  modport master (
    output code_in,
    output code_valid,
    output char_ready,
    input  code_ready,
    input  char_out,
    input  char_valid,
    input  err_count
  );
endinterface

// File: rtl/polybius_code_serializer.sv
// polybius_code_serializer
//   Turns a decimal Polybius cipher code (tens = row, ones = column, each
//   1..GRID) into a stream of ASCII digit characters, one per handshake:
//   tens digit, ones digit, then an optional separator. Codes outside the
//   grid (including 0 and anything above 99) are emitted as "??" and counted.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of polybius_code_serializer_if
//          code_in/code_valid/code_ready  - code acceptance handshake
//          char_out/char_valid/char_ready - character output handshake
//          err_count                      - invalid codes accepted (saturates)
module polybius_code_serializer #(
  parameter int unsigned GRID      = 7,
  parameter bit          SEP_EN    = 1'b1,
  parameter logic [7:0]  SEPARATOR = 8'h20
) (
  input  logic                             clk,
  input  logic                             rst,
  polybius_code_serializer_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TENS = 2'd1,
    ONES = 2'd2,
    SEP  = 2'd3
  } state_t;

  localparam logic [7:0] GRID_B     = 8'(GRID);
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_QMARK = 8'h3F;
  // The state after which a new code may be taken without a bubble.
  localparam state_t     LAST       = SEP_EN ? SEP : ONES;

  state_t      state;
  state_t      state_next;

  logic [7:0]  tens_c;
  logic [7:0]  ones_c;
  logic        invalid_c;

  logic [7:0]  tens_q;
  logic [7:0]  ones_q;
  logic        inv_q;
  logic [15:0] err_q;

  logic        code_ready_c;
  logic        accept;
  logic [7:0]  char_c;
  logic        char_valid_c;

  // Digit split of the incoming code and validity against the grid.
  always_comb begin
    tens_c    = bus.code_in / 8'd10;
    ones_c    = bus.code_in % 8'd10;
    invalid_c = (bus.code_in > 8'd99) ||
                (tens_c == 8'd0) || (tens_c > GRID_B) ||
                (ones_c == 8'd0) || (ones_c > GRID_B);
  end

  // Ready in IDLE, or in the last state when its character leaves this cycle,
  // so a new code can overlap the final handshake.
  always_comb begin
    code_ready_c = 1'b0;
    if (!rst) begin
      code_ready_c = (state == IDLE) || ((state == LAST) && bus.char_ready);
    end
  end

  assign accept = bus.code_valid && code_ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = TENS;
        end
      end
      TENS: begin
        if (bus.char_ready) begin
          state_next = ONES;
        end
      end
      ONES: begin
        if (bus.char_ready) begin
          if (SEP_EN) begin
            state_next = SEP;
          end else begin
            state_next = accept ? TENS : IDLE;
          end
        end
      end
      SEP: begin
        if (bus.char_ready) begin
          state_next = accept ? TENS : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding registers change only on capture, which keeps char_out stable
  // through any amount of backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q <= '0;
      ones_q <= '0;
      inv_q  <= 1'b0;
    end else if (accept) begin
      tens_q <= tens_c;
      ones_q <= ones_c;
      inv_q  <= invalid_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (accept && invalid_c && (err_q != '1)) begin
      err_q <= err_q + 16'd1;
    end
  end

  always_comb begin
    char_c       = 8'h00;
    char_valid_c = 1'b0;
    case (state)
      IDLE: begin
        char_c       = 8'h00;
        char_valid_c = 1'b0;
      end
      TENS: begin
        char_c       = inv_q ? CHAR_QMARK : (CHAR_ZERO + tens_q);
        char_valid_c = 1'b1;
      end
      ONES: begin
        char_c       = inv_q ? CHAR_QMARK : (CHAR_ZERO + ones_q);
        char_valid_c = 1'b1;
      end
      SEP: begin
        char_c       = SEPARATOR;
        char_valid_c = 1'b1;
      end
      default: begin
        char_c       = 8'h00;
        char_valid_c = 1'b0;
      end
    endcase
  end

  assign bus.code_ready = code_ready_c;
  assign bus.char_out   = char_c;
  assign bus.char_valid = char_valid_c;
  assign bus.err_count  = err_q;

endmodule
